// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed digit scanner
// feeding a BCD-to-7-segment decoder one digit at a time.
module bcd_scan_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic [3:0]          bcd_out,
  output logic [DIGITS-1:0]   digit_sel
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [W-1:0]      load_clean;
  logic [W-1:0]      stepped;
  logic              ripple;
  logic [W-1:0]      count_next;
  logic              wrap_next;

  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_next;
  logic              div_last;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [DIGITS-1:0] sel_next;

  // Count path: sanitised load value and one BCD step with ripple carry/borrow.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    load_clean = '0;
    stepped    = count;
    ripple     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
      if (ripple) begin
        if (up) begin
          if (count[4*i +: 4] >= 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = count[4*i +: 4] + 4'd1;
            ripple            = 1'b0;
          end
        end else begin
          if (count[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = count[4*i +: 4] - 4'd1;
            ripple            = 1'b0;
          end
        end
      end
    end
  end

  // ripple survives the top digit only when every digit wrapped.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_clean;
    end else if (en) begin
      count_next = stepped;
      wrap_next  = ripple;
    end
  end

  // Scanner: free-running divider advancing the digit index.
  always_comb begin
    div_last = (div == DIV_W'(SCAN_DIV - 1));
    div_next = div_last ? '0 : div + DIV_W'(1);
    idx_next = idx;
    if (div_last) begin
      idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
    sel_next = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_next == IDX_W'(i)) sel_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (!rst_n) begin
      count     <= '0;
      wrap      <= 1'b0;
      div       <= '0;
      idx       <= '0;
      digit_sel <= DIGITS'(1);
    end else begin
      count     <= count_next;
      wrap      <= wrap_next;
      div       <= div_next;
      idx       <= idx_next;
      digit_sel <= sel_next;
    end
  end

  // Digit mux straight off the count register, so bcd_out tracks count in the same cycle.
  always_comb begin
    bcd_out = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx == IDX_W'(i)) bcd_out = count[4*i +: 4];
    end
  end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Multi-digit BCD up/down counter with a time-multiplexed digit scanner.
- Sits directly upstream of the BCD-to-7-segment decoder.
- Presents one 4-bit BCD digit at a time on bcd_out, with a one-hot digit_sel strobe to drive common-anode/cathode enables.
- Also exposes the full packed count and a wrap pulse for cascading.

Parameters:
- DIGITS, 4, number of BCD digits (>=1); digit 0 is least significant.
- SCAN_DIV, 4, clock cycles each digit is held on bcd_out before the scanner advances (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_val  input  4*DIGITS  packed BCD load value, digit i at [4i+3:4i]
- count  output  4*DIGITS  packed BCD count register
- wrap  output  1  one-cycle pulse on overflow (up) or underflow (down)
- bcd_out  output  4  BCD digit currently scanned, to decoder input
- digit_sel  output  DIGITS  one-hot select of scanned digit, bit i = digit i

Behaviour:
Reset (rst_n=0 at a clock edge; synchronous, overrides everything):
- count=0, wrap=0, scan index=0, divider=0.
- digit_sel=...0001, bcd_out=0.
- Reset asserted mid-count or mid-scan takes effect at the next edge; no partial update survives.

Count path, priority load > en:
- load=1: count <= load_val; wrap <= 0.
  - Any loaded nibble >9 is stored as 0; other nibbles are stored unchanged.
- load=0, en=1, up=1: BCD increment with ripple carry within the same cycle.
  - A digit at 9 goes to 0 and carries into the next digit; no binary digits A-F ever appear.
  - All digits at 9 -> all 0, and wrap <= 1 for exactly that cycle.
- load=0, en=1, up=0: BCD decrement with ripple borrow.
  - A digit at 0 goes to 9 and borrows from the next digit.
  - All digits at 0 -> all 9, and wrap <= 1.
- load=0, en=0: count holds; wrap <= 0.
- wrap is registered. It is high only in the cycle after the wrapping edge, when count already shows the wrapped value.

Scanner (free-running; independent of en/load):
- Divider counts 0..SCAN_DIV-1. On the edge where the divider is at SCAN_DIV-1:
  - divider <= 0;
  - scan index <= (index+1) mod DIGITS;
  - digit_sel rotates one position left, and from the top bit back to bit 0.
- SCAN_DIV=1: the index advances every cycle.
- digit_sel is always exactly one-hot and matches the scan index.
- bcd_out = nibble of the count register selected by the scan index. It is a combinational mux of registers, so a count change is visible on bcd_out in the same cycle it appears on count.
- Full scan period = DIGITS*SCAN_DIV cycles.

Boundary conditions:
- load and en high together: load wins and no step occurs.
- Direction change between consecutive enabled cycles: each step uses the up value sampled at that edge.
- DIGITS=1: digit_sel is constantly 1; wrap fires on 9->0 and 0->9.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with en=1, load=1 -> count=0000, wrap=0, digit_sel=0001, bcd_out=0; release -> count 0001 after first enabled edge.
- Increment carry: load 0x0199, en=1, up=1 for 2 cycles -> count 0x0200 then 0x0201; load 0x9999, 1 step -> count 0x0000 and wrap=1 for exactly one cycle.
- Decrement borrow: load 0x1000, up=0, 1 step -> 0x0999; load 0x0000, 1 step -> 0x9999 with single-cycle wrap.
- Invalid load and priority: load_val=0x3A7F -> count 0x3070; load=1,en=1 with load_val=0x0042 -> count 0x0042, no step that cycle.
- Scanner: count fixed at 0x4321, SCAN_DIV=4 -> bcd_out 1,2,3,4 with digit_sel 0001,0010,0100,1000, each held 4 cycles, repeating every 16 cycles regardless of en.
- Scan/count interaction: en=1 while scanning -> bcd_out always equals count[4*idx+3:4*idx] for the one-hot index, every cycle; checker compares continuously.
